// File: rtl/p_slave_responder.sv
// Wait-state slave responder: captures one request, waits WAIT_CYCLES, then completes it against a reset-cleared word store.
// Optional build macro P_SLAVE_RESPONDER_ERR_EN: out-of-range addresses give an error response instead of wrapping.
module p_slave_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  // state | meaning
  // IDLE  | no transfer; accept req_valid and capture the request
  // WAIT  | wait-state countdown on the captured request
  // RESP  | req_ready high for one cycle; writes land on the edge leaving RESP
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state, state_next;
  logic [3:0]            wait_cnt;
  logic                  cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [IDX_W-1:0]      sel_idx, cap_idx;
  logic                  sel_oob, cap_oob;
  logic                  ready_d, err_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  // With zero wait states RESP is entered on the accept edge, before the capture registers hold the request.
  assign sel_write = (state == IDLE) ? req_write : cap_write;
  assign sel_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign sel_idx   = sel_addr[IDX_W-1:0];
  assign cap_idx   = cap_addr[IDX_W-1:0];

`ifdef P_SLAVE_RESPONDER_ERR_EN
  assign sel_oob = (sel_addr >> IDX_W) != '0;
  assign cap_oob = (cap_addr >> IDX_W) != '0;
`else
  logic unused_addr_bits;
  assign sel_oob = 1'b0;
  assign cap_oob = 1'b0;
  assign unused_addr_bits = ^{sel_addr, cap_addr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= ready_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if (state_next == RESP) begin
      ready_d = 1'b1;
      err_d   = sel_oob;
      if (!sel_write && !sel_oob) rdata_d = mem[sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == RESP && cap_write && !cap_oob) mem[cap_idx] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_p_slave_responder.sv
// Scoreboard bench for p_slave_responder: dut (WAIT_CYCLES=2) and dut_w0 (WAIT_CYCLES=0).
module tb_p_slave_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       rv, rw, rdy, re;
  logic [1:0][7:0]  ra;
  logic [1:0][31:0] rwd, rd;

  p_slave_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_ready(rdy[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));

  p_slave_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_ready(rdy[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rdy = 0;
  int   ws[2] = '{2, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %h expected %h (cycle %0d)", nm, what, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per req_ready pulse; outputs must be quiet otherwise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d got ready=1 expected none (cycle %0d)", d, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.nm, "dut", 32'(d), 32'(e.d));
          chk(e.nm, "ready_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk_rd) chk(e.nm, "rdata", rd[d], e.rdata);
          chk(e.nm, "err", {31'd0, re[d]}, {31'd0, e.err});
        end
      end else begin
        checks++;
        if (rdy[d] !== 1'b0 || rd[d] !== 32'd0 || re[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs dut%0d got ready=%b rdata=%h err=%b expected 0/0/0 (cycle %0d)",
                   d, rdy[d], rd[d], re[d], cyc);
        end
      end
    end
  end

  task automatic issue(input int d, input bit b2b, input bit hold, input bit mutate, input bit wr,
                       input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input bit exp_err, input string nm);
    exp_t e;
    int   acc;
    bit   seen;
    if (!b2b) @(negedge clk);
    acc = b2b ? last_rdy + 2 : cyc + 1;
    rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd;
    e.d = d; e.cyc = acc + ws[d]; e.rdata = exp_rd; e.chk_rd = !wr; e.err = exp_err; e.nm = nm;
    sb.push_back(e);
    seen = 1'b0;
    if (mutate) begin
      @(negedge clk);
      ra[d]  = a + 8'd1;
      rwd[d] = ~wd;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no ready expected ready within 40 cycles", nm);
    end
    last_rdy = cyc;
    if (!hold) rv[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rv  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rv = '0; rw = '0; ra = '0; rwd = '0;
    do_reset();
    chk("reset", "ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset", "rdata", rd[0], 32'd0);

    // Fresh read after reset, then write/read back-to-back.
    issue(0, 0, 0, 0, 0, 8'h03, 32'h0, 32'h0, 0, "read_after_reset");
    issue(0, 0, 1, 0, 1, 8'h05, 32'hDEADBEEF, 32'h0, 0, "write_5");
    issue(0, 1, 0, 0, 0, 8'h05, 32'h0, 32'hDEADBEEF, 0, "b2b_read_5");
    issue(0, 0, 0, 0, 0, 8'h04, 32'h0, 32'h0, 0, "read_4_untouched");

    // Request inputs change during WAIT; only the captured values count.
    issue(0, 0, 0, 1, 1, 8'h06, 32'h11111111, 32'h0, 0, "write_6_mutated");
    issue(0, 0, 0, 0, 0, 8'h06, 32'h0, 32'h11111111, 0, "read_6");
    issue(0, 0, 0, 0, 0, 8'h07, 32'h0, 32'h0, 0, "read_7_unwritten");

`ifdef P_SLAVE_RESPONDER_ERR_EN
    issue(0, 0, 0, 0, 1, 8'h10, 32'h12345678, 32'h0, 1, "write_oob");
    issue(0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0, 0, "read_0_after_oob");
    issue(0, 0, 0, 0, 0, 8'h10, 32'h0, 32'h0, 1, "read_oob");
`else
    issue(0, 0, 0, 0, 1, 8'h10, 32'h12345678, 32'h0, 0, "write_wrap");
    issue(0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h12345678, 0, "read_0_after_wrap");
    issue(0, 0, 0, 0, 0, 8'h15, 32'h0, 32'hDEADBEEF, 0, "read_15_wraps_to_5");
`endif

    // Reset during WAIT of a write: no ready pulse, no store, memory cleared.
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'h02; rwd[0] = 32'hA5A5A5A5;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv[0] = 1'b0;
    repeat (5) @(negedge clk);
    issue(0, 0, 0, 0, 0, 8'h02, 32'h0, 32'h0, 0, "read_2_after_abort");
    issue(0, 0, 0, 0, 0, 8'h05, 32'h0, 32'h0, 0, "read_5_cleared");

    // Zero wait states.
    issue(1, 0, 1, 0, 1, 8'h00, 32'h00000001, 32'h0, 0, "w0_write_0");
    issue(1, 1, 0, 0, 0, 8'h00, 32'h0, 32'h00000001, 0, "w0_read_0");
    issue(1, 0, 0, 0, 0, 8'h09, 32'h0, 32'h0, 0, "w0_read_9");

    repeat (4) @(negedge clk);
    chk("end", "scoreboard_left", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_slave_responder.md
P_SLAVE_RESPONDER -- requirements
Module: p_slave_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, request address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write and read data width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of storage words; power of two, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response; range 0..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: master holds a transfer request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits: word address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port req_ready, output, 1 bit: transfer completes this cycle.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, valid while req_ready=1 on a read.
REQ-013 SHALL have port rsp_err, output, 1 bit: error response, valid while req_ready=1.

Function
REQ-014 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-015 In IDLE with req_valid=1, SHALL capture req_write, req_addr and req_wdata, then move to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, SHALL count WAIT_CYCLES cycles, then move to RESP.
REQ-017 In RESP, SHALL drive req_ready=1 for exactly one cycle, then return to IDLE.
REQ-018 Request latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to the req_ready cycle.
REQ-019 All outputs SHALL be registered; req_ready, rsp_err and rsp_rdata SHALL be 0 outside RESP.
REQ-020 The master SHALL hold req_* stable until req_ready; the responder SHALL use only the captured values, so request changes after acceptance have no effect.
REQ-021 A write SHALL update mem[captured address] on the clock edge that ends RESP.
REQ-022 A read SHALL present mem[captured address] on rsp_rdata during RESP.
REQ-023 A read after a write to the same address SHALL return the new data.
REQ-024 The cycle after RESP SHALL be IDLE; a held req_valid is accepted there, giving a back-to-back period of WAIT_CYCLES+2 cycles.
REQ-025 With req_valid=0 in IDLE, SHALL stay in IDLE with no storage change.

Reset
REQ-026 With rst=1 at a clock edge, SHALL enter IDLE, clear the wait counter and drive req_ready, rsp_err and rsp_rdata to 0.
REQ-027 Reset SHALL clear all DEPTH storage words to 0.
REQ-028 Reset during WAIT or RESP SHALL abandon the transfer with no storage write and no req_ready pulse.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 When macro P_SLAVE_RESPONDER_ERR_EN is defined, a captured address >= DEPTH SHALL produce rsp_err=1 in RESP, suppress the write and return rsp_rdata=0.
REQ-031 When P_SLAVE_RESPONDER_ERR_EN is undefined, addresses SHALL wrap modulo DEPTH (low log2(DEPTH) bits used) and rsp_err SHALL be constant 0.

Verification
REQ-032 Reset then read of address 0x3 -> req_ready high exactly 3 cycles after acceptance, rsp_rdata=0x00000000, rsp_err=0.
REQ-033 Write 0xDEADBEEF to 0x5, then read 0x5 back-to-back -> read returns 0xDEADBEEF; second acceptance occurs the cycle after the first RESP.
REQ-034 WAIT_CYCLES=0: write 0x1 to 0x0 -> req_ready asserted the cycle after acceptance; then read 0x0 -> 0x00000001.
REQ-035 Assert rst during WAIT of a write of 0xA5A5A5A5 to 0x2 -> no req_ready pulse; a later read of 0x2 returns 0.
REQ-036 With P_SLAVE_RESPONDER_ERR_EN: write 0x12345678 to 0x10 -> rsp_err=1; read 0x0 -> 0. Without it, the same write then a read of 0x0 -> 0x12345678, rsp_err=0.
REQ-037 Change req_addr and req_wdata during WAIT -> response uses the captured values only.
